// File: rtl/jpeg_mcu_cnt_pkg.sv
// Shared types and constants for the JPEG MCU/block position tracker.
// Optional restart-interval support is enabled with JPEG_MCU_RSTI_EN.
package jpeg_mcu_cnt_pkg;

    typedef enum logic [2:0] {
        mcu_idle = 3'd0,
        mcu_calc = 3'd1,
        mcu_run  = 3'd2,
        mcu_done = 3'd3,
        mcu_err  = 3'd4
    } mcu_state_e;

    // Top-level decoder state code that requests a synchronous clear.
    localparam logic [3:0] state_rst = 4'd0;

    localparam logic [1:0] comp_y  = 2'd0;
    localparam logic [1:0] comp_cr = 2'd1;
    localparam logic [1:0] comp_cb = 2'd2;

    localparam logic [2:0] blk_per_mcu_411 = 3'd6;
    localparam logic [2:0] blk_per_mcu_444 = 3'd3;

    // MCUs needed to cover one picture dimension (ceil to 8 or 16 pixels).
    function automatic logic [12:0] mcu_span(input logic [15:0] dim, input logic is_411);
        logic [16:0] sum;
        sum = {1'b0, dim} + (is_411 ? 17'd15 : 17'd7);
        return is_411 ? sum[16:4] : sum[15:3];
    endfunction

endpackage

// File: rtl/jpeg_mcu_cnt_if.sv
// SOF/block-progress bundle between the decoder (master) and the MCU tracker (slave).
// dri/rst_due exist only when JPEG_MCU_RSTI_EN is defined.
interface jpeg_mcu_cnt_if;

    logic        res_avali;
    logic [15:0] width;
    logic [15:0] heigth;
    logic        pic_is_411;
    logic [1:0]  sof_y_qt;
    logic [1:0]  sof_cr_qt;
    logic [1:0]  sof_cb_qt;
    logic        blk_done;

    logic        cfg_valid;
    logic        pic_err;
    logic [12:0] mcu_w;
    logic [12:0] mcu_h;
    logic [12:0] mcu_x;
    logic [12:0] mcu_y;
    logic [1:0]  blk_comp;
    logic [1:0]  blk_y_idx;
    logic [1:0]  blk_qt;
    logic        pic_done;

`ifdef JPEG_MCU_RSTI_EN
    logic [15:0] dri;
    logic        rst_due;

    modport master (
        output res_avali, width, heigth, pic_is_411, sof_y_qt, sof_cr_qt, sof_cb_qt,
               blk_done, dri,
        input  cfg_valid, pic_err, mcu_w, mcu_h, mcu_x, mcu_y, blk_comp, blk_y_idx,
               blk_qt, pic_done, rst_due
    );

    modport slave (
        input  res_avali, width, heigth, pic_is_411, sof_y_qt, sof_cr_qt, sof_cb_qt,
               blk_done, dri,
        output cfg_valid, pic_err, mcu_w, mcu_h, mcu_x, mcu_y, blk_comp, blk_y_idx,
               blk_qt, pic_done, rst_due
    );
`else
    modport master (
        output res_avali, width, heigth, pic_is_411, sof_y_qt, sof_cr_qt, sof_cb_qt,
               blk_done,
        input  cfg_valid, pic_err, mcu_w, mcu_h, mcu_x, mcu_y, blk_comp, blk_y_idx,
               blk_qt, pic_done
    );

    modport slave (
        input  res_avali, width, heigth, pic_is_411, sof_y_qt, sof_cr_qt, sof_cb_qt,
               blk_done,
        output cfg_valid, pic_err, mcu_w, mcu_h, mcu_x, mcu_y, blk_comp, blk_y_idx,
               blk_qt, pic_done
    );
`endif

endinterface

// File: rtl/jpeg_mcu_cnt_rst_itv.sv
// Restart-interval counter: counts completed MCUs and flags when a restart marker is due.
// Instantiated by jpeg_mcu_cnt only when JPEG_MCU_RSTI_EN is defined.
module jpeg_rst_itv (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] dri,
    input  logic        mcu_end,
    input  logic        pic_last,
    output logic        rst_due
);

    logic [15:0] dri_l;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;

    assign cnt_nxt = cnt + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dri_l   <= '0;
            cnt     <= '0;
            rst_due <= 1'b0;
        end else if (clr) begin
            dri_l   <= '0;
            cnt     <= '0;
            rst_due <= 1'b0;
        end else begin
            rst_due <= 1'b0;
            if (load) begin
                dri_l <= dri;
                cnt   <= '0;
            end else if (mcu_end) begin
                // No marker follows the final MCU; the EOI marker comes instead.
                if ((dri_l != 16'd0) && (cnt_nxt == dri_l) && !pic_last) begin
                    rst_due <= 1'b1;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/jpeg_mcu_cnt.sv
// MCU grid / block position tracker fed by the SOF parser and block-completion pulses.
// Define JPEG_MCU_RSTI_EN to add the restart-interval counter (dri/rst_due).
module jpeg_mcu_cnt
    import jpeg_mcu_cnt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    jpeg_mcu_cnt_if.slave bus
);

    mcu_state_e  fsm;
    mcu_state_e  fsm_nxt;

    logic        res_q;
    logic        is411_l;
    logic [1:0]  qt_y_l;
    logic [1:0]  qt_cr_l;
    logic [1:0]  qt_cb_l;
    logic [12:0] mcu_w_r;
    logic [12:0] mcu_h_r;
    logic [12:0] mcu_x_r;
    logic [12:0] mcu_y_r;
    logic [2:0]  blk_cnt;
    logic        pic_err_r;
    logic        pic_done_r;

    logic        clr;
    logic        res_rise;
    logic        dims_ok;
    logic [2:0]  blk_last_idx;
    logic        last_blk;
    logic        last_col;
    logic        last_row;
    logic        last_pic;
    logic        adv;

    assign clr          = (state == state_rst);
    assign res_rise     = bus.res_avali & ~res_q;
    assign dims_ok      = (bus.width != 16'd0) && (bus.heigth != 16'd0);
    assign blk_last_idx = is411_l ? (blk_per_mcu_411 - 3'd1) : (blk_per_mcu_444 - 3'd1);
    assign last_blk     = (blk_cnt == blk_last_idx);
    assign last_col     = (mcu_x_r == mcu_w_r - 13'd1);
    assign last_row     = (mcu_y_r == mcu_h_r - 13'd1);
    assign last_pic     = last_blk && last_col && last_row;
    assign adv          = (fsm == mcu_run) && bus.blk_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm <= mcu_idle;
        end else if (clr) begin
            fsm <= mcu_idle;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            mcu_idle: if (res_rise) fsm_nxt = mcu_calc;
            mcu_calc: fsm_nxt = dims_ok ? mcu_run : mcu_err;
            mcu_run:  if (adv && last_pic) fsm_nxt = mcu_done;
            mcu_done: fsm_nxt = mcu_done;
            mcu_err:  fsm_nxt = mcu_err;
            default:  fsm_nxt = mcu_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q      <= 1'b0;
            is411_l    <= 1'b0;
            qt_y_l     <= '0;
            qt_cr_l    <= '0;
            qt_cb_l    <= '0;
            mcu_w_r    <= '0;
            mcu_h_r    <= '0;
            mcu_x_r    <= '0;
            mcu_y_r    <= '0;
            blk_cnt    <= '0;
            pic_err_r  <= 1'b0;
            pic_done_r <= 1'b0;
        end else if (clr) begin
            res_q      <= 1'b0;
            is411_l    <= 1'b0;
            qt_y_l     <= '0;
            qt_cr_l    <= '0;
            qt_cb_l    <= '0;
            mcu_w_r    <= '0;
            mcu_h_r    <= '0;
            mcu_x_r    <= '0;
            mcu_y_r    <= '0;
            blk_cnt    <= '0;
            pic_err_r  <= 1'b0;
            pic_done_r <= 1'b0;
        end else begin
            res_q      <= bus.res_avali;
            pic_done_r <= 1'b0;
            if (fsm == mcu_calc) begin
                is411_l   <= bus.pic_is_411;
                qt_y_l    <= bus.sof_y_qt;
                qt_cr_l   <= bus.sof_cr_qt;
                qt_cb_l   <= bus.sof_cb_qt;
                mcu_w_r   <= mcu_span(bus.width, bus.pic_is_411);
                mcu_h_r   <= mcu_span(bus.heigth, bus.pic_is_411);
                pic_err_r <= !dims_ok;
            end
            if (adv) begin
                if (!last_blk) begin
                    blk_cnt <= blk_cnt + 3'd1;
                end else if (last_pic) begin
                    // Position stays on the final block once the picture is finished.
                    pic_done_r <= 1'b1;
                end else begin
                    blk_cnt <= '0;
                    if (last_col) begin
                        mcu_x_r <= '0;
                        mcu_y_r <= mcu_y_r + 13'd1;
                    end else begin
                        mcu_x_r <= mcu_x_r + 13'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.blk_comp  = comp_y;
        bus.blk_y_idx = 2'd0;
        if (is411_l) begin
            if (blk_cnt < 3'd4) begin
                bus.blk_y_idx = blk_cnt[1:0];
            end else begin
                bus.blk_comp = (blk_cnt == 3'd4) ? comp_cr : comp_cb;
            end
        end else begin
            bus.blk_comp = blk_cnt[1:0];
        end
    end

    always_comb begin
        case (bus.blk_comp)
            comp_cr: bus.blk_qt = qt_cr_l;
            comp_cb: bus.blk_qt = qt_cb_l;
            default: bus.blk_qt = qt_y_l;
        endcase
    end

    assign bus.cfg_valid = (fsm == mcu_run) || (fsm == mcu_done);
    assign bus.pic_err   = pic_err_r;
    assign bus.mcu_w     = mcu_w_r;
    assign bus.mcu_h     = mcu_h_r;
    assign bus.mcu_x     = mcu_x_r;
    assign bus.mcu_y     = mcu_y_r;
    assign bus.pic_done  = pic_done_r;

`ifdef JPEG_MCU_RSTI_EN
    jpeg_rst_itv u_rst_itv (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (fsm == mcu_calc),
        .dri      (bus.dri),
        .mcu_end  (adv && last_blk),
        .pic_last (last_col && last_row),
        .rst_due  (bus.rst_due)
    );
`endif

endmodule

// File: tb/tb_jpeg_mcu_cnt.sv
// Directed bench for jpeg_mcu_cnt: grid table, block walks, clear/reset corner cases.
// Restart-interval checks are included when JPEG_MCU_RSTI_EN is defined.
module tb_jpeg_mcu_cnt;
    import jpeg_mcu_cnt_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] state;

    jpeg_mcu_cnt_if bus();

    jpeg_mcu_cnt dut (
        .clk   (clk),
        .rst   (rst),
        .state (state),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is411;
        logic [15:0] w;
        logic [15:0] h;
        logic [12:0] ew;
        logic [12:0] eh;
        logic        err;
    } cfg_vec_t;

    typedef struct {
        logic [1:0]  comp;
        logic [1:0]  yidx;
        logic [12:0] x;
        logic [12:0] y;
        logic [1:0]  qt;
        logic        done;
    } step_t;

    int n_chk  = 0;
    int n_fail = 0;

    cfg_vec_t cfg_tab [8];
    step_t    walk444 [7];
    step_t    walk411 [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_clear();
        bus.res_avali = 1'b0;
        bus.blk_done  = 1'b0;
        state = state_rst;
        tick();
        state = 4'd1;
        tick();
    endtask

    task automatic do_load(input logic is411, input logic [15:0] w, input logic [15:0] h);
        bus.pic_is_411 = is411;
        bus.width      = w;
        bus.heigth     = h;
        bus.sof_y_qt   = 2'd1;
        bus.sof_cr_qt  = 2'd2;
        bus.sof_cb_qt  = 2'd3;
        bus.res_avali  = 1'b1;
        tick();
        chk("calc_cfg_valid", int'(bus.cfg_valid), 0);
        tick();
    endtask

    task automatic pulse();
        bus.blk_done = 1'b1;
        tick();
        bus.blk_done = 1'b0;
    endtask

    task automatic chk_step(input string tag, input int i, input step_t s);
        chk($sformatf("%s%0d_comp", tag, i), int'(bus.blk_comp), int'(s.comp));
        chk($sformatf("%s%0d_yidx", tag, i), int'(bus.blk_y_idx), int'(s.yidx));
        chk($sformatf("%s%0d_x", tag, i), int'(bus.mcu_x), int'(s.x));
        chk($sformatf("%s%0d_y", tag, i), int'(bus.mcu_y), int'(s.y));
        chk($sformatf("%s%0d_qt", tag, i), int'(bus.blk_qt), int'(s.qt));
        chk($sformatf("%s%0d_done", tag, i), int'(bus.pic_done), int'(s.done));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cfg_valid"}, int'(bus.cfg_valid), 0);
        chk({tag, "_pic_err"}, int'(bus.pic_err), 0);
        chk({tag, "_mcu_w"}, int'(bus.mcu_w), 0);
        chk({tag, "_mcu_h"}, int'(bus.mcu_h), 0);
        chk({tag, "_mcu_x"}, int'(bus.mcu_x), 0);
        chk({tag, "_mcu_y"}, int'(bus.mcu_y), 0);
        chk({tag, "_blk_comp"}, int'(bus.blk_comp), 0);
        chk({tag, "_blk_y_idx"}, int'(bus.blk_y_idx), 0);
        chk({tag, "_blk_qt"}, int'(bus.blk_qt), 0);
        chk({tag, "_pic_done"}, int'(bus.pic_done), 0);
    endtask

    initial begin
        cfg_tab[0] = '{1'b0, 16'd16,    16'd8,   13'd2,    13'd1,  1'b0};
        cfg_tab[1] = '{1'b1, 16'd17,    16'd16,  13'd2,    13'd1,  1'b0};
        cfg_tab[2] = '{1'b0, 16'd0,     16'd8,   13'd0,    13'd1,  1'b1};
        cfg_tab[3] = '{1'b1, 16'd640,   16'd480, 13'd40,   13'd30, 1'b0};
        cfg_tab[4] = '{1'b0, 16'd1,     16'd1,   13'd1,    13'd1,  1'b0};
        cfg_tab[5] = '{1'b1, 16'd16,    16'd0,   13'd1,    13'd0,  1'b1};
        cfg_tab[6] = '{1'b0, 16'd65520, 16'd9,   13'd8190, 13'd2,  1'b0};
        cfg_tab[7] = '{1'b1, 16'd1,     16'd1,   13'd1,    13'd1,  1'b0};

        walk444[0] = '{2'd0, 2'd0, 13'd0, 13'd0, 2'd1, 1'b0};
        walk444[1] = '{2'd1, 2'd0, 13'd0, 13'd0, 2'd2, 1'b0};
        walk444[2] = '{2'd2, 2'd0, 13'd0, 13'd0, 2'd3, 1'b0};
        walk444[3] = '{2'd0, 2'd0, 13'd1, 13'd0, 2'd1, 1'b0};
        walk444[4] = '{2'd1, 2'd0, 13'd1, 13'd0, 2'd2, 1'b0};
        walk444[5] = '{2'd2, 2'd0, 13'd1, 13'd0, 2'd3, 1'b0};
        walk444[6] = '{2'd2, 2'd0, 13'd1, 13'd0, 2'd3, 1'b1};

        walk411[0]  = '{2'd0, 2'd0, 13'd0, 13'd0, 2'd1, 1'b0};
        walk411[1]  = '{2'd0, 2'd1, 13'd0, 13'd0, 2'd1, 1'b0};
        walk411[2]  = '{2'd0, 2'd2, 13'd0, 13'd0, 2'd1, 1'b0};
        walk411[3]  = '{2'd0, 2'd3, 13'd0, 13'd0, 2'd1, 1'b0};
        walk411[4]  = '{2'd1, 2'd0, 13'd0, 13'd0, 2'd2, 1'b0};
        walk411[5]  = '{2'd2, 2'd0, 13'd0, 13'd0, 2'd3, 1'b0};
        walk411[6]  = '{2'd0, 2'd0, 13'd1, 13'd0, 2'd1, 1'b0};
        walk411[7]  = '{2'd0, 2'd1, 13'd1, 13'd0, 2'd1, 1'b0};
        walk411[8]  = '{2'd0, 2'd2, 13'd1, 13'd0, 2'd1, 1'b0};
        walk411[9]  = '{2'd0, 2'd3, 13'd1, 13'd0, 2'd1, 1'b0};
        walk411[10] = '{2'd1, 2'd0, 13'd1, 13'd0, 2'd2, 1'b0};
        walk411[11] = '{2'd2, 2'd0, 13'd1, 13'd0, 2'd3, 1'b0};
        walk411[12] = '{2'd2, 2'd0, 13'd1, 13'd0, 2'd3, 1'b1};

        rst            = 1'b0;
        state          = 4'd1;
        bus.res_avali  = 1'b0;
        bus.width      = '0;
        bus.heigth     = '0;
        bus.pic_is_411 = 1'b0;
        bus.sof_y_qt   = '0;
        bus.sof_cr_qt  = '0;
        bus.sof_cb_qt  = '0;
        bus.blk_done   = 1'b0;
`ifdef JPEG_MCU_RSTI_EN
        bus.dri        = 16'd0;
`endif
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();

        // Grid arithmetic and zero-dimension detection.
        for (int i = 0; i < 8; i++) begin
            do_clear();
            do_load(cfg_tab[i].is411, cfg_tab[i].w, cfg_tab[i].h);
            chk($sformatf("cfg%0d_cfg_valid", i), int'(bus.cfg_valid), int'(!cfg_tab[i].err));
            chk($sformatf("cfg%0d_pic_err", i), int'(bus.pic_err), int'(cfg_tab[i].err));
            chk($sformatf("cfg%0d_mcu_w", i), int'(bus.mcu_w), int'(cfg_tab[i].ew));
            chk($sformatf("cfg%0d_mcu_h", i), int'(bus.mcu_h), int'(cfg_tab[i].eh));
        end

        // 4:4:4 walk, then extra blk_done after completion.
        do_clear();
        do_load(1'b0, 16'd16, 16'd8);
        chk_step("w444_", 0, walk444[0]);
        for (int i = 1; i < 7; i++) begin
            pulse();
            chk_step("w444_", i, walk444[i]);
        end
        tick();
        chk("w444_done_pulse_end", int'(bus.pic_done), 0);
        pulse();
        chk("extra_done", int'(bus.pic_done), 0);
        chk("extra_comp", int'(bus.blk_comp), 2);
        chk("extra_x", int'(bus.mcu_x), 1);
        chk("extra_cfg_valid", int'(bus.cfg_valid), 1);

        // 4:1:1 walk; SOF inputs change after latching and must be ignored.
        do_clear();
        do_load(1'b1, 16'd17, 16'd16);
        bus.pic_is_411 = 1'b0;
        bus.sof_y_qt   = 2'd0;
        bus.sof_cr_qt  = 2'd0;
        bus.sof_cb_qt  = 2'd0;
        bus.width      = 16'd8;
        bus.res_avali  = 1'b0;
        chk_step("w411_", 0, walk411[0]);
        for (int i = 1; i < 13; i++) begin
            pulse();
            chk_step("w411_", i, walk411[i]);
        end
        chk("w411_mcu_w", int'(bus.mcu_w), 2);

        // Zero width: error state ignores blk_done.
        do_clear();
        do_load(1'b0, 16'd0, 16'd8);
        chk("err_pic_err", int'(bus.pic_err), 1);
        chk("err_cfg_valid", int'(bus.cfg_valid), 0);
        pulse();
        chk("err_comp", int'(bus.blk_comp), 0);
        chk("err_done", int'(bus.pic_done), 0);
        chk("err_sticky", int'(bus.pic_err), 1);

        // Synchronous clear wins over a simultaneous blk_done.
        do_clear();
        do_load(1'b0, 16'd16, 16'd8);
        pulse();
        pulse();
        pulse();
        chk("pre_clr_x", int'(bus.mcu_x), 1);
        bus.blk_done  = 1'b1;
        bus.res_avali = 1'b0;
        state = state_rst;
        tick();
        bus.blk_done = 1'b0;
        state = 4'd1;
        chk_all_zero("sclr");
        tick();
        do_load(1'b0, 16'd16, 16'd8);
        chk("restart_cfg_valid", int'(bus.cfg_valid), 1);
        chk("restart_x", int'(bus.mcu_x), 0);
        chk("restart_comp", int'(bus.blk_comp), 0);
        pulse();
        chk("restart_step_comp", int'(bus.blk_comp), 1);

        // Asynchronous reset mid-run clears outputs without a clock edge.
        pulse();
        pulse();
        chk("pre_arst_x", int'(bus.mcu_x), 1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("arst");
        tick();
        rst = 1'b1;
        tick();

`ifdef JPEG_MCU_RSTI_EN
        // Restart interval of 2 MCUs over a 4-MCU row.
        do_clear();
        bus.dri = 16'd2;
        do_load(1'b0, 16'd32, 16'd8);
        chk("rsti_mcu_w", int'(bus.mcu_w), 4);
        bus.dri = 16'd1;
        for (int i = 1; i <= 12; i++) begin
            pulse();
            chk($sformatf("rsti_due%0d", i), int'(bus.rst_due), (i == 6) ? 1 : 0);
            chk($sformatf("rsti_done%0d", i), int'(bus.pic_done), (i == 12) ? 1 : 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
